inst_rom_loader: RTL and testbench

//   Responder end of the core's instruction-fetch interface (rom_ce/rom_addr out, rom_data in).

---
 rtl/inst_rom_loader.sv | 127 ++++++++++++
 tb/tb_inst_rom_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_loader.sv
// inst_rom_loader: word-wide instruction memory with a zero-latency fetch port
// and a byte-serial boot loader. The core is held in reset until an image is loaded.
module inst_rom_loader #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rom_ce_i,
  input  logic [31:0]           rom_addr_i,
  output logic [31:0]           rom_data_o,
  input  logic                  load_start_i,
  input  logic [DEPTH_LOG2:0]   load_len_i,
  input  logic                  load_valid_i,
  input  logic [7:0]            load_byte_i,
  output logic                  load_ready_o,
  output logic                  load_done_o,
  output logic [7:0]            load_sum_o,
  output logic                  cpu_hold_o,
  output logic                  addr_err_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] MAX_LEN = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] ONE     = {{DEPTH_LOG2{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                  state;
  logic [DEPTH_LOG2:0]     word_cnt;
  logic [DEPTH_LOG2:0]     len_q;
  logic [1:0]              byte_cnt;
  logic [23:0]             shift;
  logic [31:0]             mem [DEPTH];

  logic [DEPTH_LOG2:0]     len_c;
  logic                    accept;
  logic                    mem_we;
  logic                    last_word;
  logic                    addr_ok;
  logic [DEPTH_LOG2-1:0]   rd_idx;

  // Decode of loader handshake, length clamp and fetch address legality
  always_comb begin
    len_c     = (load_len_i > MAX_LEN) ? MAX_LEN : load_len_i;
    accept    = (state == LOAD) && load_ready_o && load_valid_i && !load_start_i;
    mem_we    = !rst && accept && (byte_cnt == 2'd3);
    last_word = (word_cnt == (len_q - ONE));
    addr_ok   = (rom_addr_i[1:0] == 2'b00) && (rom_addr_i[31:DEPTH_LOG2+2] == '0);
    rd_idx    = rom_addr_i[DEPTH_LOG2+1:2];
  end

  // Loader / run-control FSM with registered handshake and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      word_cnt     <= '0;
      byte_cnt     <= '0;
      len_q        <= '0;
      shift        <= '0;
      load_sum_o   <= '0;
      load_ready_o <= 1'b0;
      load_done_o  <= 1'b0;
      cpu_hold_o   <= 1'b1;
      addr_err_o   <= 1'b0;
    end else if (load_start_i) begin
      word_cnt   <= '0;
      byte_cnt   <= '0;
      shift      <= '0;
      load_sum_o <= '0;
      addr_err_o <= 1'b0;
      len_q      <= len_c;
      if (len_c == '0) begin
        state        <= RUN;
        load_done_o  <= 1'b1;
        cpu_hold_o   <= 1'b0;
        load_ready_o <= 1'b0;
      end else begin
        state        <= LOAD;
        load_done_o  <= 1'b0;
        cpu_hold_o   <= 1'b1;
        load_ready_o <= 1'b1;
      end
    end else begin
      case (state)
        IDLE: begin
          cpu_hold_o   <= 1'b1;
          load_ready_o <= 1'b0;
        end
        LOAD: begin
          if (accept) begin
            load_sum_o <= load_sum_o + load_byte_i;
            if (byte_cnt == 2'd3) begin
              byte_cnt <= '0;
              shift    <= '0;
              word_cnt <= word_cnt + ONE;
              if (last_word) begin
                state        <= RUN;
                load_done_o  <= 1'b1;
                cpu_hold_o   <= 1'b0;
                load_ready_o <= 1'b0;
              end
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
              shift    <= {shift[15:0], load_byte_i};
            end
          end
        end
        RUN: begin
          if (rom_ce_i && !addr_ok) addr_err_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Instruction memory write port; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[word_cnt[DEPTH_LOG2-1:0]] <= {shift, load_byte_i};
  end

  // Zero-latency fetch; returns zero outside RUN or for illegal addresses
  always_comb begin
    rom_data_o = '0;
    if (!rst && (state == RUN) && rom_ce_i && addr_ok) rom_data_o = mem[rd_idx];
  end

endmodule

// File: tb/tb_inst_rom_loader.sv
// Self-checking bench for inst_rom_loader: directed scenarios plus randomized
// traffic compared every cycle against a transaction-level model.
module tb_inst_rom_loader;

  localparam int DL    = 10;
  localparam int DEPTH = 1 << DL;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic [31:0] rom_data_o;
  logic        load_start_i;
  logic [DL:0] load_len_i;
  logic        load_valid_i;
  logic [7:0]  load_byte_i;
  logic        load_ready_o;
  logic        load_done_o;
  logic [7:0]  load_sum_o;
  logic        cpu_hold_o;
  logic        addr_err_o;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  inst_rom_loader #(.DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst(rst),
    .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i), .rom_data_o(rom_data_o),
    .load_start_i(load_start_i), .load_len_i(load_len_i),
    .load_valid_i(load_valid_i), .load_byte_i(load_byte_i),
    .load_ready_o(load_ready_o), .load_done_o(load_done_o),
    .load_sum_o(load_sum_o), .cpu_hold_o(cpu_hold_o), .addr_err_o(addr_err_o)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int           m_mode = 0;          // 0 idle, 1 loading, 2 running
  logic [31:0]  m_mem [DEPTH];
  bit           m_known [DEPTH];
  byte unsigned m_q[$];
  int           m_words = 0;
  int           m_len = 0;
  logic [7:0]   m_sum = '0;
  bit           m_err = 1'b0;
  bit           m_done = 1'b0;

  function automatic bit addr_ok(input logic [31:0] a);
    longint unsigned la = longint'(a);
    return (la % 4 == 0) && (la < longint'(DEPTH) * 4);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_q.delete(); m_words = 0; m_sum = '0; m_err = 0; m_done = 0;
    end else if (load_start_i) begin
      m_len = (int'(load_len_i) > DEPTH) ? DEPTH : int'(load_len_i);
      m_q.delete(); m_words = 0; m_sum = '0; m_err = 0;
      if (m_len == 0) begin m_mode = 2; m_done = 1; end
      else begin m_mode = 1; m_done = 0; end
    end else if (m_mode == 1 && load_valid_i) begin
      m_q.push_back(load_byte_i);
      m_sum = m_sum + load_byte_i;
      if (m_q.size() == 4) begin
        m_mem[m_words]   = {m_q[0], m_q[1], m_q[2], m_q[3]};
        m_known[m_words] = 1'b1;
        m_words++;
        m_q.delete();
        if (m_words == m_len) begin m_mode = 2; m_done = 1; end
      end
    end else if (m_mode == 2 && rom_ce_i && !addr_ok(rom_addr_i)) begin
      m_err = 1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("hold",  {31'd0, cpu_hold_o},   {31'd0, m_mode != 2});
      chk("ready", {31'd0, load_ready_o}, {31'd0, m_mode == 1});
      chk("done",  {31'd0, load_done_o},  {31'd0, m_done});
      chk("sum",   {24'd0, load_sum_o},   {24'd0, m_sum});
      chk("err",   {31'd0, addr_err_o},   {31'd0, m_err});
      if (rst || m_mode != 2 || !rom_ce_i || !addr_ok(rom_addr_i))
        chk("rdata_zero", rom_data_o, 32'd0);
      else if (m_known[rom_addr_i[DL+1:2]])
        chk("rdata", rom_data_o, m_mem[rom_addr_i[DL+1:2]]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start(input int len);
    load_start_i = 1'b1;
    load_len_i   = len[DL:0];
    tick();
    load_start_i = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    load_valid_i = 1'b1;
    load_byte_i  = b;
    tick();
    load_valid_i = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    rom_ce_i = 1'b1; rom_addr_i = a;
    #1;
    chk(name, rom_data_o, exp);
    rom_ce_i = 1'b0; rom_addr_i = '0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0, 1:    return {20'd0, 10'($urandom_range(0, DEPTH - 1)), 2'b00};
      2:       return {20'd0, 10'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
      default: return $urandom;
    endcase
  endfunction

  logic [7:0] b3 [4];
  logic [7:0] img [8];

  initial begin
    rst = 1'b1; rom_ce_i = 1'b0; rom_addr_i = '0; load_start_i = 1'b0;
    load_len_i = '0; load_valid_i = 1'b0; load_byte_i = '0;

    // 1) reset
    tick(); chk_en = 1'b1; tick();
    chk("rst_hold", {31'd0, cpu_hold_o}, 32'd1);
    chk("rst_ready", {31'd0, load_ready_o}, 32'd0);
    chk("rst_done", {31'd0, load_done_o}, 32'd0);
    chk("rst_err", {31'd0, addr_err_o}, 32'd0);
    chk("rst_rdata", rom_data_o, 32'd0);
    rst = 1'b0;
    tick();

    // 2) two-word load
    img[0] = 8'h34; img[1] = 8'h01; img[2] = 8'h00; img[3] = 8'h05;
    img[4] = 8'h20; img[5] = 8'h02; img[6] = 8'h00; img[7] = 8'h0A;
    start(2);
    for (int i = 0; i < 8; i++) send(img[i]);
    chk("t2_done", {31'd0, load_done_o}, 32'd1);
    chk("t2_hold", {31'd0, cpu_hold_o}, 32'd0);
    chk("t2_sum", {24'd0, load_sum_o}, 32'h66);
    read_chk("t2_word1", 32'h4, 32'h2002000A);
    read_chk("t2_word0", 32'h0, 32'h34010005);

    // 3) gapped valid on a one-word load
    start(1);
    for (int i = 0; i < 4; i++) begin
      b3[i] = 8'($urandom);
      load_valid_i = 1'b1; load_byte_i = b3[i];
      tick();
      chk("t3_done_step", {31'd0, load_done_o}, {31'd0, i == 3});
      load_valid_i = 1'b0; load_byte_i = 8'($urandom);
      tick();
    end
    read_chk("t3_word", 32'h0, {b3[0], b3[1], b3[2], b3[3]});

    // 4) bad fetches in RUN
    rom_ce_i = 1'b1; rom_addr_i = 32'h2;
    #1;
    chk("t4_misalign_rdata", rom_data_o, 32'd0);
    chk("t4_err_before", {31'd0, addr_err_o}, 32'd0);
    tick();
    chk("t4_err_after", {31'd0, addr_err_o}, 32'd1);
    read_chk("t4_range_rdata", 32'h1000, 32'd0);
    rom_ce_i = 1'b0; rom_addr_i = 32'h4;
    #1;
    chk("t4_ce0_rdata", rom_data_o, 32'd0);
    tick();

    // 5) reset part-way through a load
    start(2);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_hold", {31'd0, cpu_hold_o}, 32'd1);
    chk("t5_done", {31'd0, load_done_o}, 32'd0);
    chk("t5_ready", {31'd0, load_ready_o}, 32'd0);
    start(0);
    read_chk("t5_kept", 32'h0, 32'h11223344);
    start(1);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    chk("t5_sum", {24'd0, load_sum_o}, 32'h0E);
    read_chk("t5_word", 32'h0, 32'hAABBCCDD);

    // 6) zero-length start, then reload from RUN
    start(0);
    chk("t6_done", {31'd0, load_done_o}, 32'd1);
    chk("t6_hold", {31'd0, cpu_hold_o}, 32'd0);
    start(1);
    chk("t6_rehold", {31'd0, cpu_hold_o}, 32'd1);
    read_chk("t6_blocked", 32'h0, 32'd0);
    for (int i = 0; i < 4; i++) send(8'($urandom));

    // oversize length clamps to full memory
    start(2047);
    load_valid_i = 1'b1;
    for (int i = 0; i < 4 * DEPTH; i++) begin
      load_byte_i = 8'($urandom);
      tick();
    end
    load_valid_i = 1'b0;
    chk("clamp_done", {31'd0, load_done_o}, 32'd1);

    // randomized traffic
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 19))
        0: begin rst = 1'b1; tick(); rst = 1'b0; end
        1, 2, 3: begin
          load_valid_i = 1'($urandom); load_byte_i = 8'($urandom);
          rom_ce_i = 1'($urandom); rom_addr_i = rand_addr();
          start(($urandom_range(0, 9) == 0) ? int'($urandom_range(1025, 2047))
                                            : int'($urandom_range(0, 6)));
        end
        default: begin
          for (int c = 0; c < int'($urandom_range(1, 20)); c++) begin
            load_valid_i = ($urandom_range(0, 3) != 0);
            load_byte_i  = 8'($urandom);
            rom_ce_i     = 1'($urandom);
            rom_addr_i   = rand_addr();
            tick();
          end
        end
      endcase
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
